exec_muldiv: RTL and testbench

Iterative RV32M multiply/divide unit in the execute stage, directly downstream of the ID/EX pipeline register. It consumes the latched operands, `func_3`, and `rd` from that register for M-extension instructions. It computes the result over multiple cycles and holds `busy` high so the hazard logic stalls the front end until the result is ready. The result and `rd` are handed to the EX/MEM path with a one-cycle `done` pulse.

---
 rtl/exec_muldiv.sv | 166 ++++++++++++++++
 tb/tb_exec_muldiv.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/exec_muldiv.sv
// Iterative RV32M multiply/divide: shift-add multiply, restoring divide, one bit per cycle.
// Optional MULDIV_EARLY_OUT_EN lets divide-by-zero, signed overflow and zero-operand multiply skip CALC.
module exec_muldiv #(
  parameter int DATA_WIDTH     = 32,
  parameter int R_ADRESS_WIDTH = 5
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start,
  input  logic                      flush,
  input  logic [2:0]                op,
  input  logic [DATA_WIDTH-1:0]     rs1_in,
  input  logic [DATA_WIDTH-1:0]     rs2_in,
  input  logic [R_ADRESS_WIDTH-1:0] rd_in,
  output logic                      busy,
  output logic                      done,
  output logic [DATA_WIDTH-1:0]     result,
  output logic [R_ADRESS_WIDTH-1:0] rd_out
);

  localparam int DW = DATA_WIDTH;
  localparam int CW = $clog2(DATA_WIDTH + 1);

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_FIX, S_DONE} state_t;

  state_t                    state, state_nxt;
  logic [2:0]                op_q;
  logic [R_ADRESS_WIDTH-1:0] rd_q;
  logic                      sign_a, sign_b, div_zero;
  logic [2*DW-1:0]           acc;
  logic [DW-1:0]             b_q;
  logic [CW-1:0]             cnt;

  logic          accept, a_sgn_op, b_sgn_op, neg_a, neg_b, early;
  logic [DW-1:0] abs_a, abs_b;

  assign accept   = (state == S_IDLE) && start && !flush;
  assign a_sgn_op = (op == 3'b001) || (op == 3'b010) || (op == 3'b100) || (op == 3'b110);
  assign b_sgn_op = (op == 3'b001) || (op == 3'b100) || (op == 3'b110);
  assign neg_a    = a_sgn_op && rs1_in[DW-1];
  assign neg_b    = b_sgn_op && rs2_in[DW-1];
  assign abs_a    = neg_a ? -rs1_in : rs1_in;
  assign abs_b    = neg_b ? -rs2_in : rs2_in;

`ifdef MULDIV_EARLY_OUT_EN
  logic            ovf_in;
  logic [2*DW-1:0] early_acc;
  assign ovf_in = op[2] && !op[0] && (rs1_in == {1'b1, {(DW-1){1'b0}}}) && (&rs2_in);
  assign early  = op[2] ? ((rs2_in == '0) || ovf_in) : ((rs1_in == '0) || (rs2_in == '0));
  // Preload the unsigned magnitudes CALC would have produced so FIX is shared.
  always_comb begin
    early_acc = '0;
    if (op[2] && rs2_in == '0)
      early_acc = {abs_a, {DW{1'b1}}};
    else if (op[2])
      early_acc = {{DW{1'b0}}, 1'b1, {(DW-1){1'b0}}};
  end
`else
  assign early = 1'b0;
`endif

  // One iteration of each algorithm; acc holds {hi, lo} for multiply and {rem, quo} for divide.
  logic [DW:0]     mul_sum, div_sh;
  logic [DW-1:0]   div_diff;
  logic            div_ge;
  logic [2*DW-1:0] mul_nxt, div_nxt;

  assign mul_sum  = {1'b0, acc[2*DW-1:DW]} + (acc[0] ? {1'b0, b_q} : {(DW+1){1'b0}});
  assign mul_nxt  = {mul_sum, acc[DW-1:1]};
  assign div_sh   = {acc[2*DW-1:DW], acc[DW-1]};
  assign div_ge   = div_sh >= {1'b0, b_q};
  assign div_diff = div_sh[DW-1:0] - b_q;
  assign div_nxt  = div_ge ? {div_diff, acc[DW-2:0], 1'b1}
                           : {div_sh[DW-1:0], acc[DW-2:0], 1'b0};

  logic [2*DW-1:0] prod;
  logic [DW-1:0]   quo, rem, fix_res;

  assign prod = (sign_a ^ sign_b) ? -acc : acc;
  assign quo  = div_zero ? {DW{1'b1}}
                         : ((sign_a ^ sign_b) ? -acc[DW-1:0] : acc[DW-1:0]);
  assign rem  = sign_a ? -acc[2*DW-1:DW] : acc[2*DW-1:DW];

  always_comb begin
    fix_res = '0;
    case (op_q)
      3'b000:                 fix_res = prod[DW-1:0];
      3'b001, 3'b010, 3'b011: fix_res = prod[2*DW-1:DW];
      3'b100, 3'b101:         fix_res = quo;
      default:                fix_res = rem;
    endcase
  end

  always_comb begin
    state_nxt = state;
    busy      = 1'b0;
    done      = 1'b0;
    case (state)
      S_IDLE: begin
        busy = accept;
        if (accept) state_nxt = early ? S_FIX : S_CALC;
      end
      S_CALC: begin
        busy = 1'b1;
        if (flush)                 state_nxt = S_IDLE;
        else if (cnt == CW'(1))    state_nxt = S_FIX;
      end
      S_FIX: begin
        busy      = 1'b1;
        state_nxt = flush ? S_IDLE : S_DONE;
      end
      default: begin
        done      = !flush;
        state_nxt = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_IDLE;
      cnt      <= '0;
      result   <= '0;
      rd_out   <= '0;
      op_q     <= '0;
      rd_q     <= '0;
      sign_a   <= 1'b0;
      sign_b   <= 1'b0;
      div_zero <= 1'b0;
      acc      <= '0;
      b_q      <= '0;
    end else begin
      state <= state_nxt;
      case (state)
        S_IDLE: begin
          if (accept) begin
            op_q     <= op;
            rd_q     <= rd_in;
            sign_a   <= neg_a;
            sign_b   <= neg_b;
            div_zero <= op[2] && (rs2_in == '0);
            cnt      <= CW'(DATA_WIDTH);
            // Divide: acc.lo = dividend, b = divisor. Multiply: acc.lo = multiplier, b = multiplicand.
            b_q      <= op[2] ? abs_b : abs_a;
            acc      <= {{DW{1'b0}}, (op[2] ? abs_a : abs_b)};
`ifdef MULDIV_EARLY_OUT_EN
            if (early) acc <= early_acc;
`endif
          end
        end
        S_CALC: begin
          acc <= op_q[2] ? div_nxt : mul_nxt;
          cnt <= cnt - CW'(1);
        end
        S_FIX: begin
          if (!flush) begin
            result <= fix_res;
            rd_out <= rd_q;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_exec_muldiv.sv
// Directed-vector bench for exec_muldiv: result table plus flush/reset/corner sequences.
module tb_exec_muldiv;

  logic        clk = 1'b0;
  logic        rst, start, flush;
  logic [2:0]  op;
  logic [31:0] rs1_in, rs2_in;
  logic [4:0]  rd_in;
  logic        busy, done;
  logic [31:0] result;
  logic [4:0]  rd_out;

  exec_muldiv #(.DATA_WIDTH(32), .R_ADRESS_WIDTH(5)) dut (
    .clk(clk), .rst(rst), .start(start), .flush(flush), .op(op),
    .rs1_in(rs1_in), .rs2_in(rs2_in), .rd_in(rd_in),
    .busy(busy), .done(done), .result(result), .rd_out(rd_out)
  );

  always #5 clk = ~clk;

  localparam int LAT_FULL = 34;
`ifdef MULDIV_EARLY_OUT_EN
  localparam int LAT_SPECIAL = 2;
`else
  localparam int LAT_SPECIAL = 34;
`endif

  int tests = 0;
  int fails = 0;

  typedef struct {
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [4:0]  rd;
    logic        special;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs[18];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issues one op at cycle 0 and follows it to its done pulse.
  task automatic do_op(input string name, input logic [2:0] o, input logic [31:0] a,
                       input logic [31:0] b, input logic [4:0] rd,
                       input int exp_lat, input logic [31:0] exp_res);
    int done_cyc;
    int busy_bad;
    start = 1'b1; op = o; rs1_in = a; rs2_in = b; rd_in = rd;
    @(negedge clk);
    chk({name, " busy@0"}, 32'(busy), 32'd1);
    tick();
    start = 1'b0; rs1_in = $urandom; rs2_in = $urandom; rd_in = ~rd; op = ~o;
    done_cyc = -1;
    busy_bad = 0;
    for (int c = 1; c <= 60; c++) begin
      @(negedge clk);
      if (done) begin
        done_cyc = c;
        chk({name, " result"}, result, exp_res);
        chk({name, " rd_out"}, 32'(rd_out), 32'(rd));
        chk({name, " busy@done"}, 32'(busy), 32'd0);
        tick();
        break;
      end
      if (!busy) busy_bad++;
      tick();
    end
    chk({name, " latency"}, 32'(done_cyc), 32'(exp_lat));
    chk({name, " busy gaps"}, 32'(busy_bad), 32'd0);
    @(negedge clk);
    chk({name, " done 1 cycle"}, 32'(done), 32'd0);
  endtask

  initial begin
    int  lat;
    int  seen;
    vecs = '{
      '{3'b000, 32'd7,        32'hFFFFFFFD, 5'd3,  1'b0, 32'hFFFFFFEB},
      '{3'b001, 32'h80000000, 32'h80000000, 5'd4,  1'b0, 32'h40000000},
      '{3'b011, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd5,  1'b0, 32'hFFFFFFFE},
      '{3'b010, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd6,  1'b0, 32'hFFFFFFFF},
      '{3'b001, 32'hFFFFFFFD, 32'd7,        5'd7,  1'b0, 32'hFFFFFFFF},
      '{3'b000, 32'h12345678, 32'h00010000, 5'd8,  1'b0, 32'h56780000},
      '{3'b100, 32'hFFFFFFF9, 32'd2,        5'd9,  1'b0, 32'hFFFFFFFD},
      '{3'b110, 32'hFFFFFFF9, 32'd2,        5'd10, 1'b0, 32'hFFFFFFFF},
      '{3'b101, 32'd100,      32'd7,        5'd11, 1'b0, 32'd14},
      '{3'b111, 32'd100,      32'd7,        5'd12, 1'b0, 32'd2},
      '{3'b101, 32'hFFFFFFFF, 32'd1,        5'd13, 1'b0, 32'hFFFFFFFF},
      '{3'b101, 32'd5,        32'd0,        5'd14, 1'b1, 32'hFFFFFFFF},
      '{3'b111, 32'd5,        32'd0,        5'd15, 1'b1, 32'd5},
      '{3'b100, 32'hFFFFFFF9, 32'd0,        5'd16, 1'b1, 32'hFFFFFFFF},
      '{3'b110, 32'hFFFFFFF9, 32'd0,        5'd17, 1'b1, 32'hFFFFFFF9},
      '{3'b100, 32'h80000000, 32'hFFFFFFFF, 5'd18, 1'b1, 32'h80000000},
      '{3'b110, 32'h80000000, 32'hFFFFFFFF, 5'd19, 1'b1, 32'h00000000},
      '{3'b000, 32'd0,        32'd12345,    5'd20, 1'b1, 32'h00000000}
    };

    rst = 1'b1; start = 1'b0; flush = 1'b0; op = '0;
    rs1_in = '0; rs2_in = '0; rd_in = '0;
    tick();
    tick();
    rst = 1'b0;
    @(negedge clk);
    chk("reset busy", 32'(busy), 32'd0);
    chk("reset done", 32'(done), 32'd0);
    chk("reset result", result, 32'd0);
    chk("reset rd_out", 32'(rd_out), 32'd0);
    tick();

    for (int i = 0; i < 18; i++) begin
      lat = vecs[i].special ? LAT_SPECIAL : LAT_FULL;
      do_op($sformatf("vec%0d", i), vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].rd,
            lat, vecs[i].exp);
      tick();
    end

    // Flush mid-CALC: op started at cycle 0, flush at cycle 10.
    start = 1'b1; op = 3'b100; rs1_in = 32'd1000; rs2_in = 32'd3; rd_in = 5'd21;
    tick();
    start = 1'b0;
    seen = 0;
    for (int c = 1; c < 10; c++) begin
      @(negedge clk);
      if (done) seen++;
      tick();
    end
    flush = 1'b1;
    @(negedge clk);
    if (done) seen++;
    tick();
    flush = 1'b0;
    #1;
    chk("flush busy@11", 32'(busy), 32'd0);
    chk("flush no done", 32'(seen), 32'd0);
    do_op("after flush", 3'b101, 32'd100, 32'd7, 5'd22, LAT_FULL, 32'd14);
    tick();

    // start together with flush in IDLE must be ignored.
    start = 1'b1; flush = 1'b1; op = 3'b000; rs1_in = 32'd3; rs2_in = 32'd4; rd_in = 5'd23;
    @(negedge clk);
    chk("start+flush busy", 32'(busy), 32'd0);
    tick();
    start = 1'b0; flush = 1'b0;
    seen = 0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (done || busy) seen++;
      tick();
    end
    chk("start+flush no accept", 32'(seen), 32'd0);

    // Flush in the DONE cycle suppresses done.
    start = 1'b1; op = 3'b000; rs1_in = 32'd6; rs2_in = 32'd9; rd_in = 5'd24;
    tick();
    start = 1'b0;
    for (int c = 1; c < LAT_FULL; c++) tick();
    flush = 1'b1;
    @(negedge clk);
    chk("flush in DONE done", 32'(done), 32'd0);
    chk("flush in DONE busy", 32'(busy), 32'd0);
    tick();
    flush = 1'b0;
    @(negedge clk);
    chk("flush in DONE after", 32'(done), 32'd0);
    tick();

    // Reset at cycle 20 of a divide.
    start = 1'b1; op = 3'b100; rs1_in = 32'd5000; rs2_in = 32'd7; rd_in = 5'd25;
    tick();
    start = 1'b0;
    seen = 0;
    for (int c = 1; c < 20; c++) begin
      @(negedge clk);
      if (done) seen++;
      tick();
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #1;
    chk("rst busy", 32'(busy), 32'd0);
    chk("rst done", 32'(done), 32'd0);
    chk("rst result", result, 32'd0);
    chk("rst rd_out", 32'(rd_out), 32'd0);
    chk("rst no early done", 32'(seen), 32'd0);
    do_op("after rst", 3'b111, 32'd100, 32'd7, 5'd26, LAT_FULL, 32'd2);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    fails++;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $fatal(1);
  end

endmodule
